fetch_queue: RTL and testbench

FETCH_QUEUE -- requirements
Module: fetch_queue

---
 rtl/fetch_queue.sv | 148 ++++++++++++++
 tb/tb_fetch_queue.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// Instruction fetch queue: issues word-aligned fetches under a credit limit,
// queues in-order responses with their addresses, flushes on INT/redirect and
// discards responses to requests that were in flight at the flush.
module fetch_queue #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned MAXOUT = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] entryPoint,
  input  logic        INT,
  input  logic        redirect,
  input  logic [31:0] redirectPC,
  output logic        imReq,
  output logic [31:0] imAddr,
  input  logic        imReady,
  input  logic        imValid,
  input  logic [31:0] imData,
  output logic [31:0] ins,
  output logic [31:0] insPC,
  output logic        insValid,
  input  logic        insReady
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

  state_e        state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] out_q, out_d;
  logic [CW-1:0] drop_q, drop_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [PW-1:0] wptr_q, wptr_d;
  logic          imReq_q, imReq_d;
  logic [31:0]   imAddr_q, imAddr_d;
  logic          insValid_q, insValid_d;
  logic [31:0]   ins_q, ins_d;
  logic [31:0]   insPC_q, insPC_d;

  logic [31:0]   data_mem_q [DEPTH];
  logic [31:0]   addr_mem_q [DEPTH];

  logic          issue, resp, pop, push, flush;
  logic [31:0]   target, push_addr;
  logic [CW:0]   credit_sum;

  // Next-state logic: credits, flush/drain control, queue pointers and registered outputs.
  always_comb begin
    issue      = imReq_q & imReady;
    resp       = imValid & (out_q != '0);
    pop        = insValid_q & insReady;
    flush      = INT | (redirect & (state_q != IDLE));
    target     = (INT ? entryPoint : redirectPC) & 32'hFFFF_FFFC;
    push       = resp & (state_q == RUN) & ~flush;
    // In RUN the outstanding requests are the last out_q words issued, so the
    // oldest one sits out_q words behind the PC.
    push_addr  = pc_q - (32'(out_q) << 2);

    state_d    = state_q;
    pc_d       = pc_q;
    count_d    = count_q;
    drop_d     = drop_q;
    rptr_d     = rptr_q;
    wptr_d     = wptr_q;
    out_d      = out_q + CW'(issue) - CW'(resp);

    if (flush) begin
      pc_d    = target;
      count_d = '0;
      rptr_d  = '0;
      wptr_d  = '0;
      drop_d  = out_d;
      state_d = (out_d == '0) ? RUN : DRAIN;
    end else begin
      if (issue) pc_d = pc_q + 32'd4;
      count_d = count_q + CW'(push) - CW'(pop);
      if (push) wptr_d = wptr_q + PW'(1);
      if (pop)  rptr_d = rptr_q + PW'(1);
      if (state_q == DRAIN) begin
        if (resp) drop_d = drop_q - CW'(1);
        if (drop_d == '0) state_d = RUN;
      end
    end

    credit_sum = (CW+1)'(count_d) + (CW+1)'(out_d);
    imReq_d    = (state_d == RUN) && (out_d < CW'(MAXOUT)) && (credit_sum < (CW+1)'(DEPTH));
    imAddr_d   = pc_d;
    insValid_d = (count_d != '0);

    // Head lookahead: a word written this cycle becomes the head if it lands at rptr_d.
    if (push && (wptr_q == rptr_d)) begin
      ins_d   = imData;
      insPC_d = push_addr;
    end else begin
      ins_d   = data_mem_q[rptr_d];
      insPC_d = addr_mem_q[rptr_d];
    end
  end

  // Control state and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      pc_q       <= '0;
      count_q    <= '0;
      out_q      <= '0;
      drop_q     <= '0;
      rptr_q     <= '0;
      wptr_q     <= '0;
      imReq_q    <= 1'b0;
      imAddr_q   <= '0;
      insValid_q <= 1'b0;
      ins_q      <= '0;
      insPC_q    <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      count_q    <= count_d;
      out_q      <= out_d;
      drop_q     <= drop_d;
      rptr_q     <= rptr_d;
      wptr_q     <= wptr_d;
      imReq_q    <= imReq_d;
      imAddr_q   <= imAddr_d;
      insValid_q <= insValid_d;
      ins_q      <= ins_d;
      insPC_q    <= insPC_d;
    end
  end

  // Queue storage: instruction word and its fetch address.
  always_ff @(posedge clk) begin
    if (push) begin
      data_mem_q[wptr_q] <= imData;
      addr_mem_q[wptr_q] <= push_addr;
    end
  end

  assign imReq    = imReq_q;
  assign imAddr   = imAddr_q;
  assign insValid = insValid_q;
  assign ins      = ins_q;
  assign insPC    = insPC_q;

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed vector table, hand-written corner sequences
// and a randomized run against a queue-based reference model.
module tb_fetch_queue;

  localparam int unsigned DEPTH  = 4;
  localparam int unsigned MAXOUT = 2;
  localparam int M_IDLE = 0, M_RUN = 1, M_DRAIN = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] entryPoint, redirectPC, imData, imAddr, ins, insPC;
  logic        INT, redirect, imReq, imReady, imValid, insValid, insReady;

  int n_pass = 0;
  int n_total = 0;

  fetch_queue #(.DEPTH(DEPTH), .MAXOUT(MAXOUT)) dut (
    .clk(clk), .reset(reset), .entryPoint(entryPoint), .INT(INT),
    .redirect(redirect), .redirectPC(redirectPC), .imReq(imReq), .imAddr(imAddr),
    .imReady(imReady), .imValid(imValid), .imData(imData), .ins(ins),
    .insPC(insPC), .insValid(insValid), .insReady(insReady)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic idle_inputs();
    INT = 1'b0; redirect = 1'b0; imReady = 1'b0; imValid = 1'b0; insReady = 1'b0;
    entryPoint = '0; redirectPC = '0; imData = '0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
  endtask

  // Reference model: request address queue, instruction queue, mode and PC.
  int          m_state;
  logic [31:0] m_pc;
  logic [31:0] oq[$];
  logic [31:0] iq_a[$];
  logic [31:0] iq_d[$];

  function automatic bit model_req();
    return (m_state == M_RUN) && (oq.size() < MAXOUT) && (iq_a.size() + oq.size() < DEPTH);
  endfunction

  task automatic model_reset();
    m_state = M_IDLE; m_pc = '0;
    oq.delete(); iq_a.delete(); iq_d.delete();
  endtask

  task automatic model_step();
    bit issue, resp, pop, flush;
    logic [31:0] a, tgt;
    issue = model_req() && imReady;
    resp  = imValid && (oq.size() != 0);
    pop   = insReady && (iq_a.size() != 0);
    flush = INT || (redirect && m_state != M_IDLE);
    tgt   = (INT ? entryPoint : redirectPC) & 32'hFFFF_FFFC;
    if (pop) begin a = iq_a.pop_front(); a = iq_d.pop_front(); end
    if (resp) begin
      a = oq.pop_front();
      if (m_state == M_RUN && !flush) begin iq_a.push_back(a); iq_d.push_back(imData); end
    end
    if (issue) begin oq.push_back(m_pc); m_pc = m_pc + 32'd4; end
    if (flush) begin
      iq_a.delete(); iq_d.delete();
      m_pc = tgt;
      m_state = (oq.size() == 0) ? M_RUN : M_DRAIN;
    end else if (m_state == M_DRAIN && oq.size() == 0) begin
      m_state = M_RUN;
    end
  endtask

  task automatic model_compare();
    check("rnd_imReq", {31'd0, imReq}, {31'd0, model_req()});
    if (model_req()) check("rnd_imAddr", imAddr, m_pc);
    check("rnd_insValid", {31'd0, insValid}, {31'd0, iq_a.size() != 0});
    if (iq_a.size() != 0) begin
      check("rnd_insPC", insPC, iq_a[0]);
      check("rnd_ins", ins, iq_d[0]);
    end
  endtask

  typedef struct {
    logic        int_i;
    logic [31:0] entry;
    logic        redir;
    logic [31:0] rpc;
    logic        rdy;
    logic        vld;
    logic [31:0] data;
    logic        take;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_pc;
    logic [31:0] e_ins;
  } vec_t;

  vec_t vt[13];

  // Drives a fetch up to two outstanding requests starting at address 0.
  task automatic fill_two_outstanding();
    INT = 1'b1; entryPoint = 32'h0; imReady = 1'b1;
    tick();
    INT = 1'b0;
    tick();
    tick();
    imReady = 1'b0;
    check("seq_credit_stall", {31'd0, imReq}, 32'd0);
  endtask

  initial begin
    // Start-up, nominal streaming, back-pressure fill, INT-vs-redirect priority.
    vt[0]  = '{1'b1, 32'h28, 1'b0, 32'h0,  1'b1, 1'b0, 32'h0,         1'b0, 1'b1, 32'h28, 1'b0, 32'h0,  32'h0};
    vt[1]  = '{1'b0, 32'h0,  1'b0, 32'h0,  1'b1, 1'b0, 32'h0,         1'b0, 1'b1, 32'h2C, 1'b0, 32'h0,  32'h0};
    vt[2]  = '{1'b0, 32'h0,  1'b0, 32'h0,  1'b1, 1'b1, 32'hC0DE0028,  1'b0, 1'b1, 32'h30, 1'b1, 32'h28, 32'hC0DE0028};
    vt[3]  = '{1'b0, 32'h0,  1'b0, 32'h0,  1'b1, 1'b1, 32'hC0DE002C,  1'b0, 1'b1, 32'h34, 1'b1, 32'h28, 32'hC0DE0028};
    vt[4]  = '{1'b0, 32'h0,  1'b0, 32'h0,  1'b1, 1'b1, 32'hC0DE0030,  1'b0, 1'b0, 32'h38, 1'b1, 32'h28, 32'hC0DE0028};
    vt[5]  = '{1'b0, 32'h0,  1'b0, 32'h0,  1'b1, 1'b1, 32'hC0DE0034,  1'b0, 1'b0, 32'h38, 1'b1, 32'h28, 32'hC0DE0028};
    vt[6]  = '{1'b0, 32'h0,  1'b0, 32'h0,  1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h38, 1'b1, 32'h2C, 32'hC0DE002C};
    vt[7]  = '{1'b0, 32'h0,  1'b0, 32'h0,  1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 32'h3C, 1'b1, 32'h30, 32'hC0DE0030};
    vt[8]  = '{1'b0, 32'h0,  1'b0, 32'h0,  1'b1, 1'b1, 32'hC0DE0038,  1'b1, 1'b1, 32'h40, 1'b1, 32'h34, 32'hC0DE0034};
    vt[9]  = '{1'b1, 32'h40, 1'b1, 32'h80, 1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 32'h40, 1'b0, 32'h0,  32'h0};
    vt[10] = '{1'b0, 32'h0,  1'b0, 32'h0,  1'b0, 1'b1, 32'hDEAD003C,  1'b0, 1'b1, 32'h40, 1'b0, 32'h0,  32'h0};
    vt[11] = '{1'b0, 32'h0,  1'b0, 32'h0,  1'b1, 1'b0, 32'h0,         1'b0, 1'b1, 32'h44, 1'b0, 32'h0,  32'h0};
    vt[12] = '{1'b0, 32'h0,  1'b0, 32'h0,  1'b0, 1'b1, 32'hC0DE0040,  1'b0, 1'b1, 32'h44, 1'b1, 32'h40, 32'hC0DE0040};

    // Reset values while reset is held.
    idle_inputs();
    reset = 1'b1;
    tick();
    check("rst_imReq", {31'd0, imReq}, 32'd0);
    check("rst_imAddr", imAddr, 32'd0);
    check("rst_insValid", {31'd0, insValid}, 32'd0);
    check("rst_ins", ins, 32'd0);
    check("rst_insPC", insPC, 32'd0);
    reset = 1'b0;
    tick();
    check("idle_imReq", {31'd0, imReq}, 32'd0);

    // Vector table.
    for (int i = 0; i < 13; i++) begin
      INT = vt[i].int_i; entryPoint = vt[i].entry; redirect = vt[i].redir;
      redirectPC = vt[i].rpc; imReady = vt[i].rdy; imValid = vt[i].vld;
      imData = vt[i].data; insReady = vt[i].take;
      tick();
      check($sformatf("vec%0d_imReq", i), {31'd0, imReq}, {31'd0, vt[i].e_req});
      if (vt[i].e_req) check($sformatf("vec%0d_imAddr", i), imAddr, vt[i].e_addr);
      check($sformatf("vec%0d_insValid", i), {31'd0, insValid}, {31'd0, vt[i].e_valid});
      if (vt[i].e_valid) begin
        check($sformatf("vec%0d_insPC", i), insPC, vt[i].e_pc);
        check($sformatf("vec%0d_ins", i), ins, vt[i].e_ins);
      end
    end

    // PC wrap at the top of the address space.
    do_reset();
    INT = 1'b1; entryPoint = 32'hFFFF_FFFC; imReady = 1'b1;
    tick();
    INT = 1'b0;
    check("wrap_first", imAddr, 32'hFFFF_FFFC);
    tick();
    imReady = 1'b0;
    check("wrap_req", {31'd0, imReq}, 32'd1);
    check("wrap_second", imAddr, 32'h0000_0000);

    // Unaligned entry point is forced to a word boundary.
    do_reset();
    INT = 1'b1; entryPoint = 32'h2B;
    tick();
    INT = 1'b0;
    check("align_req", {31'd0, imReq}, 32'd1);
    check("align_addr", imAddr, 32'h28);

    // Redirect with two outstanding: drain both, then refetch at the target.
    do_reset();
    fill_two_outstanding();
    redirect = 1'b1; redirectPC = 32'h100;
    tick();
    redirect = 1'b0;
    check("drain_req0", {31'd0, imReq}, 32'd0);
    check("drain_valid0", {31'd0, insValid}, 32'd0);
    imValid = 1'b1; imData = 32'hDEAD0000;
    tick();
    check("drain_req1", {31'd0, imReq}, 32'd0);
    check("drain_valid1", {31'd0, insValid}, 32'd0);
    imData = 32'hDEAD0004;
    tick();
    imValid = 1'b0;
    check("drain_done_req", {31'd0, imReq}, 32'd1);
    check("drain_done_addr", imAddr, 32'h100);
    check("drain_done_valid", {31'd0, insValid}, 32'd0);
    imReady = 1'b1;
    tick();
    imReady = 1'b0; imValid = 1'b1; imData = 32'hC0DE0100;
    tick();
    imValid = 1'b0;
    check("refetch_valid", {31'd0, insValid}, 32'd1);
    check("refetch_pc", insPC, 32'h100);
    check("refetch_ins", ins, 32'hC0DE0100);

    // Asynchronous reset in DRAIN, then stray responses.
    do_reset();
    fill_two_outstanding();
    redirect = 1'b1; redirectPC = 32'h200;
    tick();
    redirect = 1'b0;
    #2 reset = 1'b1;
    #1;
    check("async_imReq", {31'd0, imReq}, 32'd0);
    check("async_imAddr", imAddr, 32'd0);
    check("async_insValid", {31'd0, insValid}, 32'd0);
    check("async_ins", ins, 32'd0);
    check("async_insPC", insPC, 32'd0);
    tick();
    reset = 1'b0;
    imValid = 1'b1; imData = 32'hBAD0BAD0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stray_insValid", {31'd0, insValid}, 32'd0);
      check("stray_imReq", {31'd0, imReq}, 32'd0);
    end

    // Randomized run against the reference model.
    do_reset();
    model_reset();
    for (int i = 0; i < 3000; i++) begin
      INT        = (i == 0) || ($urandom_range(0, 59) == 0);
      entryPoint = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom();
      redirect   = ($urandom_range(0, 24) == 0);
      redirectPC = $urandom();
      imReady    = ($urandom_range(0, 9) < 7);
      imValid    = ($urandom_range(0, 1) == 1);
      imData     = $urandom();
      insReady   = ($urandom_range(0, 9) < 6);
      model_step();
      tick();
      model_compare();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
